// File: rtl/aes_spi_target.sv
// SPI target front end for the AES core: deserializes data+key,
// launches the core, then shifts the 128-bit result back out.
module aes_spi_target #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cs_n,
    input  logic            sdi,
    output logic            sdo,
    output logic            core_start,
    output logic [127:0]    core_data,
    output logic [Nk*32-1:0] core_key,
    input  logic            core_done,
    input  logic [127:0]    core_result,
    output logic            busy,
    output logic            frame_err
);

    localparam int KB = Nk * 32;
    localparam int FB = 128 + KB;
    localparam logic [8:0] FB_CNT = 9'(FB);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX,
        S_LAUNCH,
        S_WAIT,
        S_TX,
        S_HOLD
    } state_t;

    state_t        state_q;
    logic [FB-2:0] shift_q;
    logic [FB-1:0] shift_d;
    logic [126:0]  tx_q;
    logic [8:0]    cnt_q;
    logic [8:0]    cnt_d;
    logic          sdo_q;
    logic          start_q;
    logic          busy_q;
    logic          ferr_q;
    logic [127:0]  data_q;
    logic [KB-1:0] key_q;
    logic          abort;

    // Nr only matters to the paired core; the empty block marks odd pairings.
    if (Nr != Nk + 6) begin : g_nr_unpaired
    end

    // The shift register keeps FB-1 bits; the incoming bit completes the frame.
    assign shift_d = {shift_q, sdi};
    assign cnt_d   = cnt_q + 9'd1;
    assign abort   = cs_n && (state_q inside {S_RX, S_LAUNCH, S_WAIT, S_TX});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            tx_q    <= '0;
            cnt_q   <= '0;
            sdo_q   <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            ferr_q  <= 1'b0;
            data_q  <= '0;
            key_q   <= '0;
        end else begin
            start_q <= 1'b0;
            ferr_q  <= 1'b0;
            if (abort) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                ferr_q  <= 1'b1;
                sdo_q   <= 1'b0;
                cnt_q   <= '0;
                shift_q <= '0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (!cs_n) begin
                            shift_q <= {{(FB-2){1'b0}}, sdi};
                            cnt_q   <= 9'd1;
                            busy_q  <= 1'b1;
                            state_q <= S_RX;
                        end
                    end
                    S_RX: begin
                        shift_q <= shift_d[FB-2:0];
                        cnt_q   <= cnt_d;
                        if (cnt_d == FB_CNT) begin
                            data_q  <= shift_d[FB-1:KB];
                            key_q   <= shift_d[KB-1:0];
                            start_q <= 1'b1;
                            state_q <= S_LAUNCH;
                        end
                    end
                    S_LAUNCH: begin
                        state_q <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (core_done) begin
                            sdo_q   <= core_result[127];
                            tx_q    <= core_result[126:0];
                            cnt_q   <= '0;
                            state_q <= S_TX;
                        end
                    end
                    S_TX: begin
                        tx_q  <= {tx_q[125:0], 1'b0};
                        sdo_q <= tx_q[126];
                        cnt_q <= cnt_d;
                        if (cnt_q == 9'd127) begin
                            sdo_q   <= 1'b0;
                            state_q <= S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        if (cs_n) begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign sdo        = sdo_q;
    assign core_start = start_q;
    assign core_data  = data_q;
    assign core_key   = key_q;
    assign busy       = busy_q;
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_aes_spi_target.sv
// Scoreboard bench for aes_spi_target: Nk=4 and Nk=8 instances,
// directed frames, aborts, stray core_done and mid-TX reset.
module tb_aes_spi_target;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         sdi = 1'b0;
    logic [1:0]   cs_n = 2'b11;
    logic [1:0]   done = 2'b00;
    logic [127:0] result = '0;
    logic [1:0]   sdo, start, busy, ferr;
    logic [127:0] data4, data8;
    logic [127:0] key4;
    logic [255:0] key8;

    aes_spi_target #(.Nk(4), .Nr(10)) u4 (
        .clk(clk), .rst(rst), .cs_n(cs_n[0]), .sdi(sdi),
        .sdo(sdo[0]), .core_start(start[0]), .core_data(data4),
        .core_key(key4), .core_done(done[0]), .core_result(result),
        .busy(busy[0]), .frame_err(ferr[0])
    );

    aes_spi_target #(.Nk(8), .Nr(14)) u8 (
        .clk(clk), .rst(rst), .cs_n(cs_n[1]), .sdi(sdi),
        .sdo(sdo[1]), .core_start(start[1]), .core_data(data8),
        .core_key(key8), .core_done(done[1]), .core_result(result),
        .busy(busy[1]), .frame_err(ferr[1])
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int inst; int cyc; logic [127:0] data; logic [255:0] key; } launch_t;
    typedef struct { int inst; int cyc; } err_t;
    typedef struct { int inst; logic [127:0] res; } res_t;

    launch_t lq[$];
    err_t    eq[$];
    res_t    rq[$];

    int n_chk = 0;
    int n_fail = 0;

    localparam logic [127:0] D1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] R1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] K8 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] R8 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] D2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] R3 = 128'hfedcba98765432100f1e2d3c4b5a6978;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUTs present an event.
    bit           launched [2];
    bit           coll [2];
    bit           ferr_prev [2];
    int           nbit [2];
    logic [127:0] got [2];
    logic [127:0] md;
    logic [255:0] mk;
    launch_t      ml;
    err_t         me;
    res_t         mr;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                launched[i]  = 1'b0;
                coll[i]      = 1'b0;
                ferr_prev[i] = 1'b0;
            end else begin
                md = (i == 1) ? data8 : data4;
                mk = (i == 1) ? key8 : {128'b0, key4};
                if (coll[i]) begin
                    got[i] = {got[i][126:0], sdo[i]};
                    nbit[i]++;
                    if (nbit[i] == 128) begin
                        coll[i] = 1'b0;
                        chk("result_pending", 256'(rq.size() != 0), 1);
                        if (rq.size() != 0) begin
                            mr = rq.pop_front();
                            chk("result_inst", i, mr.inst);
                            chk("sdo_result", got[i], mr.res);
                        end
                    end
                end else begin
                    chk("sdo_idle", sdo[i], 0);
                end
                if (done[i] && launched[i]) begin
                    launched[i] = 1'b0;
                    coll[i]     = 1'b1;
                    nbit[i]     = 0;
                    got[i]      = '0;
                end
                if (start[i]) begin
                    chk("launch_pending", 256'(lq.size() != 0), 1);
                    if (lq.size() != 0) begin
                        ml = lq.pop_front();
                        chk("launch_inst", i, ml.inst);
                        chk("launch_cycle", cyc, ml.cyc);
                        chk("core_data", md, ml.data);
                        chk("core_key", mk, ml.key);
                    end
                    launched[i] = 1'b1;
                end
                if (ferr[i]) begin
                    chk("err_pending", 256'(eq.size() != 0), 1);
                    if (eq.size() != 0) begin
                        me = eq.pop_front();
                        chk("err_inst", i, me.inst);
                        chk("err_cycle", cyc, me.cyc);
                    end
                    chk("busy_at_err", busy[i], 0);
                    chk("err_width", ferr_prev[i], 0);
                    launched[i] = 1'b0;
                    coll[i]     = 1'b0;
                end
                ferr_prev[i] = ferr[i];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input int i, input logic [127:0] d,
                              input logic [255:0] k, input int nsend);
        int nb;
        logic [383:0] fr;
        launch_t l;
        nb = (i == 1) ? 384 : 256;
        fr = (i == 1) ? {d, k} : {128'b0, d, k[127:0]};
        for (int b = 0; b < nsend; b++) begin
            cs_n[i] = 1'b0;
            sdi = fr[nb-1-b];
            if (b == nb - 1) begin
                l.inst = i;
                l.cyc  = cyc + 1;
                l.data = d;
                l.key  = (i == 1) ? k : {128'b0, k[127:0]};
                lq.push_back(l);
            end
            tick();
        end
    endtask

    task automatic raise_cs(input int i, input bit expect_err);
        err_t e;
        cs_n[i] = 1'b1;
        if (expect_err) begin
            e.inst = i;
            e.cyc  = cyc + 1;
            eq.push_back(e);
        end
        tick();
    endtask

    task automatic wait_start(input int i);
        int t = 0;
        while (!start[i] && t < 100) begin
            tick();
            t++;
        end
        chk("start_seen", start[i], 1);
    endtask

    task automatic core(input int i, input int lat, input logic [127:0] r,
                        input bit expect_tx);
        res_t e;
        wait_start(i);
        repeat (lat) tick();
        if (expect_tx) begin
            e.inst = i;
            e.res  = r;
            rq.push_back(e);
        end
        result  = r;
        done[i] = 1'b1;
        tick();
        done[i] = 1'b0;
    endtask

    task automatic full_txn(input int i, input logic [127:0] d,
                            input logic [255:0] k, input logic [127:0] r, input int lat);
        send_frame(i, d, k, (i == 1) ? 384 : 256);
        core(i, lat, r, 1'b1);
        repeat (130) tick();
        raise_cs(i, 1'b0);
        tick();
        chk("busy_after_cs", busy[i], 0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #3;
        for (int i = 0; i < 2; i++) begin
            chk("rst_sdo", sdo[i], 0);
            chk("rst_start", start[i], 0);
            chk("rst_busy", busy[i], 0);
            chk("rst_ferr", ferr[i], 0);
        end
        chk("rst_data4", data4, 0);
        chk("rst_key4", key4, 0);
        chk("rst_data8", data8, 0);
        chk("rst_key8", key8, 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Nk=4 encrypt
        full_txn(0, D1, {128'b0, K1}, R1, 20);
        chk("data4_hold", data4, D1);
        chk("key4_hold", key4, K1);

        // Nk=8
        full_txn(1, D1, K8, R8, 20);

        // Abort in RX after 100 bits, then a good frame
        send_frame(0, D2, {128'b0, K2}, 100);
        raise_cs(0, 1'b1);
        repeat (3) tick();
        chk("abort_rx_data", data4, D1);
        chk("abort_rx_key", key4, K1);
        chk("abort_rx_busy", busy[0], 0);
        full_txn(0, D2, {128'b0, K2}, R2, 7);

        // Abort in WAIT, then a late core_done in IDLE
        send_frame(0, D1, {128'b0, K1}, 256);
        wait_start(0);
        repeat (5) tick();
        raise_cs(0, 1'b1);
        tick();
        result  = R1;
        done[0] = 1'b1;
        tick();
        done[0] = 1'b0;
        repeat (4) tick();
        chk("abort_wait_busy", busy[0], 0);
        chk("abort_wait_sdo", sdo[0], 0);

        // Stray core_done in IDLE and during RX
        done[0] = 1'b1;
        tick();
        done[0] = 1'b0;
        tick();
        chk("stray_idle_busy", busy[0], 0);
        fork
            send_frame(0, R2, {128'b0, R1}, 256);
            begin
                repeat (50) tick();
                done[0] = 1'b1;
                tick();
                done[0] = 1'b0;
            end
        join
        core(0, 4, R3, 1'b1);
        repeat (130) tick();
        raise_cs(0, 1'b0);
        tick();
        chk("stray_busy_after", busy[0], 0);

        // Reset at TX bit 50
        send_frame(0, D1, {128'b0, K1}, 256);
        core(0, 10, R1, 1'b0);
        repeat (50) tick();
        rst = 1'b1;
        #1;
        chk("midtx_sdo", sdo[0], 0);
        chk("midtx_start", start[0], 0);
        chk("midtx_data", data4, 0);
        chk("midtx_key", key4, 0);
        chk("midtx_busy", busy[0], 0);
        chk("midtx_ferr", ferr[0], 0);
        @(negedge clk);
        cs_n[0] = 1'b1;
        #1 rst = 1'b0;
        repeat (3) tick();

        // Recovery after reset
        full_txn(0, D2, {128'b0, K2}, R2, 3);

        repeat (3) tick();
        chk("launch_q_empty", lq.size(), 0);
        chk("err_q_empty", eq.size(), 0);
        chk("result_q_empty", rq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/aes_spi_target.md
# aes_spi_target

Slave-side serial front end for the AES cipher core, sitting directly downstream of the SPI master on the same `clk`. It deserializes one frame of plaintext plus key from `sdi` while `cs_n` is low, then launches the AES core with a start/done handshake. It shifts the 128-bit core result back to the master on `sdo`, MSB first, and tracks frame integrity.

## Interface
- `Nk`, default 4: key length in 32-bit words (4, 6 or 8); frame length `FRAME_BITS` = 128 + Nk*32.
- `Nr`, default 10: round count, passed through for core pairing; no internal use.
- `clk` input 1: system clock; all sampling on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `cs_n` input 1: chip select, active low; frame is valid only while low.
- `sdi` input 1: serial data from master, MSB of data first, then MSB of key.
- `sdo` output 1: serial result to master, registered.
- `core_start` output 1: one-cycle pulse launching the AES core.
- `core_data` output 128: plaintext/ciphertext block to core, registered.
- `core_key` output Nk*32: key to core, registered.
- `core_done` input 1: one-cycle pulse, core result valid.
- `core_result` input 128: core output, sampled when `core_done`=1.
- `busy` output 1: high in every state except IDLE.
- `frame_err` output 1: one-cycle pulse on aborted transaction.

## Operation
- States: IDLE, RX, LAUNCH, WAIT, TX, HOLD.
- IDLE:
  - `cs_n`=0: sample `sdi` as frame bit 0, set bit counter to 1, go to RX.
  - Otherwise stay in IDLE.
- RX:
  - Each cycle with `cs_n`=0, shift `sdi` into the LSB of a FRAME_BITS shift register and increment the counter. Counter width is 9 bits, sufficient for 384.
  - When the counter reaches FRAME_BITS, go to LAUNCH.
  - On entry to LAUNCH, load `core_data` from shift bits [FRAME_BITS-1 : Nk*32] and `core_key` from bits [Nk*32-1 : 0].
- LAUNCH:
  - `core_start`=1 for exactly one cycle, then go to WAIT.
  - `core_data` and `core_key` hold their values until the next LAUNCH.
- WAIT:
  - On `core_done`=1, load `core_result` into the 128-bit TX register, clear the counter, and go to TX.
  - WAIT has no timeout; only `cs_n` or `rst` can exit it.
- TX:
  - `sdo` = TX[127]. The register shifts left by one, zero-filled, each cycle.
  - After 128 bits have been driven, go to HOLD.
- HOLD:
  - `sdo`=0. Stay until `cs_n`=1, then go to IDLE.
  - Surplus master clocks in HOLD are ignored.
- Abort:
  - `cs_n`=1 while in RX, LAUNCH, WAIT or TX: go to IDLE next cycle and pulse `frame_err` for one cycle.
  - Partial RX data is discarded; `core_data` and `core_key` keep their previous values.
  - The core is not cancelled. A late `core_done` arriving in IDLE or RX is ignored.
- `core_done` in any state other than WAIT is ignored.
- `cs_n` low again while still in IDLE after an abort starts a new frame normally.

## Timing
- Reset values: `sdo`=0, `core_start`=0, `core_data`=0, `core_key`=0, `busy`=0, `frame_err`=0. State is IDLE, counters are 0, and the shift and TX registers are 0.
- Reset takes effect immediately, mid-frame included; there is no `frame_err` on reset.
- Frame bit k is sampled on rising edge k after the first `cs_n`=0 edge (k = 0..FRAME_BITS-1).
- `core_start` is high exactly 1 cycle after the edge that sampled the last frame bit.
- First result bit appears on `sdo` 1 cycle after the `core_done` edge. Bit 127-n is driven in TX cycle n.
- Total latency, first `sdi` sample to last `sdo` bit: FRAME_BITS + 2 + core latency + 128 cycles.
- `busy` rises 1 cycle after the first sample and falls 1 cycle after `cs_n`=1 in HOLD or on abort.
- `frame_err` is asserted in the same cycle `busy` falls.

## Test plan
- Nk=4 encrypt:
  - Stimulus: frame `00112233445566778899aabbccddeeff` ++ `000102030405060708090a0b0c0d0e0f`, with the bench core returning `69c4e0d86a7b0430d8cdb78070b4c55a` after 20 cycles.
  - Required: `core_start` 1 cycle after bit 255; `core_data` and `core_key` match the frame; `sdo` serializes `69c4e0d8...c55a` MSB first; `busy` low after `cs_n`=1.
- Nk=8:
  - Stimulus: 384-bit frame with key `000102...1f`.
  - Required: `core_key` equals `000102...1f`; `core_start` after bit 383.
- Abort in RX:
  - Stimulus: `cs_n`=1 after 100 bits.
  - Required: one `frame_err` pulse; no `core_start`; `core_data` unchanged. A following full frame succeeds.
- Abort in WAIT:
  - Stimulus: `cs_n`=1 before `core_done`, then a late `core_done`.
  - Required: `frame_err` pulse; IDLE; `sdo` stays 0; late `core_done` ignored.
- Reset mid-TX:
  - Stimulus: `rst` at TX bit 50.
  - Required: all outputs at reset values immediately; no `frame_err`.
- Stray `core_done`:
  - Stimulus: `core_done` pulses in IDLE and RX.
  - Required: no state change; received frame intact.
